// File: rtl/dev_info_poller.sv
`timescale 1ns/1ps
// dev_info_poller
//   Periodically (or on a manual start) reads the eight 32-bit device-info words over an
//   Avalon-MM read master, stages them, and commits all eight at once into a shadow bank.
//   Checks the magic word and that the runtime word advances, and flags reads that hang.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   avm_*                 Avalon-MM read master (one read outstanding at a time)
//   start                 one-cycle manual poll trigger, ignored while busy
//   err_clr               clears the sticky error flags (a same-cycle set wins)
//   snap_sel / snap_data  registered read port into the shadow bank, 1-cycle latency
//   snap_valid            one-cycle pulse when a new snapshot is visible
//   snap_ready            high once any snapshot has been committed
//   magic_err             sticky: word 0 was not 32'h4D464441 at commit
//   stall_err             sticky: runtime word (2) did not change between commits
//   timeout_err           sticky: a read did not complete within TIMEOUT_CLK cycles
//   busy                  high while a poll is in progress
module dev_info_poller #(
  parameter int unsigned INPUT_CLOCK = 100_000_000,
  parameter int unsigned POLL_MS     = 100,
  parameter int unsigned TIMEOUT_CLK = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [2:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        start,
  input  logic        err_clr,
  input  logic [2:0]  snap_sel,
  output logic [31:0] snap_data,
  output logic        snap_valid,
  output logic        snap_ready,
  output logic        magic_err,
  output logic        stall_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam int unsigned MsDiv = (INPUT_CLOCK / 1000 > 0) ? INPUT_CLOCK / 1000 : 1;
  localparam int unsigned PreW  = (MsDiv > 1) ? $clog2(MsDiv) : 1;
  localparam int unsigned PollW = (POLL_MS > 1) ? $clog2(POLL_MS) : 1;
  localparam int unsigned ToW   = $clog2(TIMEOUT_CLK + 1);
  localparam logic [31:0] Magic = 32'h4D46_4441;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StCommit} state_e;

  state_e            state_q, state_d;
  logic [PreW-1:0]   pre_q, pre_d;
  logic [PollW-1:0]  poll_q, poll_d;
  logic              pend_q, pend_d;
  logic [2:0]        idx_q, idx_d;
  logic [ToW-1:0]    to_q, to_d;

  logic [31:0] staging_q [8];
  logic [31:0] shadow_q  [8];

  logic        ms_tick, poll_tick, to_expired;
  logic        capture, commit, timed_out;
  logic        magic_set, stall_set;
  logic [31:0] snap_word;

  // Timers and FSM next state
  always_comb begin
    ms_tick   = (pre_q == PreW'(MsDiv - 1));
    pre_d     = ms_tick ? '0 : pre_q + 1'b1;
    poll_tick = ms_tick && (poll_q == PollW'(POLL_MS - 1));
    poll_d    = poll_q;
    if (ms_tick) begin
      poll_d = poll_tick ? '0 : poll_q + 1'b1;
    end

    state_d    = state_q;
    idx_d      = idx_q;
    to_d       = to_q;
    pend_d     = pend_q | poll_tick;  // at most one request is remembered
    capture    = 1'b0;
    commit     = 1'b0;
    timed_out  = 1'b0;
    to_expired = (to_q >= ToW'(TIMEOUT_CLK - 1));

    unique case (state_q)
      StIdle: begin
        if (pend_q || poll_tick || start) begin
          state_d = StReq;
          idx_d   = '0;
          to_d    = '0;
          pend_d  = 1'b0;
        end
      end
      StReq: begin
        if (!avm_waitrequest) begin
          state_d = StWait;
          to_d    = to_q + 1'b1;
        end else if (to_expired) begin
          timed_out = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StWait: begin
        if (avm_readdatavalid) begin
          capture = 1'b1;
          if (idx_q == 3'd7) begin
            state_d = StCommit;
          end else begin
            idx_d   = idx_q + 3'd1;
            to_d    = '0;
            state_d = StReq;
          end
        end else if (to_expired) begin
          timed_out = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (timed_out) begin
      state_d = StIdle;
    end
  end

  // snap_data follows the bank as it will be after this edge, so the committed words and
  // snap_valid appear together and a half-written bank is never visible.
  always_comb begin
    snap_word = commit ? staging_q[snap_sel] : shadow_q[snap_sel];
    magic_set = commit && (staging_q[0] != Magic);
    stall_set = commit && snap_ready && (staging_q[2] == shadow_q[2]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pre_q   <= '0;
      poll_q  <= '0;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      poll_q  <= poll_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        staging_q[i] <= '0;
        shadow_q[i]  <= '0;
      end
      snap_data   <= '0;
      snap_valid  <= 1'b0;
      snap_ready  <= 1'b0;
      magic_err   <= 1'b0;
      stall_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (capture) begin
        staging_q[idx_q] <= avm_readdata;
      end
      if (commit) begin
        shadow_q   <= staging_q;
        snap_ready <= 1'b1;
      end
      snap_data   <= snap_word;
      snap_valid  <= commit;
      magic_err   <= magic_set | (magic_err & ~err_clr);
      stall_err   <= stall_set | (stall_err & ~err_clr);
      timeout_err <= timed_out | (timeout_err & ~err_clr);
    end
  end

  assign avm_read    = (state_q == StReq);
  assign avm_address = avm_read ? idx_q : 3'd0;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_dev_info_poller.sv
`timescale 1ns/1ps
// Bench for dev_info_poller: two instances. u_dut (no auto polls within the run, short
// timeout) takes manual polls against a randomized slave; u_auto (10 kHz clock, 2 ms
// period) checks autonomous poll spacing and the pending-request behaviour.
module tb_dev_info_poller;

  localparam int unsigned ToClk = 64;
  localparam logic [31:0] Magic = 32'h4D46_4441;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  avm_address;
  logic        avm_read, avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        start, err_clr;
  logic [2:0]  snap_sel;
  logic [31:0] snap_data;
  logic        snap_valid, snap_ready, magic_err, stall_err, timeout_err, busy;

  logic [2:0]  b_address;
  logic        b_read, b_waitrequest, b_readdatavalid;
  logic [31:0] b_readdata;
  logic        b_start;
  logic [31:0] b_snap_data;
  logic        b_snap_valid, b_snap_ready, b_magic_err, b_stall_err, b_timeout_err, b_busy;

  dev_info_poller #(.INPUT_CLOCK(100_000_000), .POLL_MS(100), .TIMEOUT_CLK(ToClk)) u_dut (
    .clk(clk), .reset(reset),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .start(start), .err_clr(err_clr), .snap_sel(snap_sel), .snap_data(snap_data),
    .snap_valid(snap_valid), .snap_ready(snap_ready), .magic_err(magic_err),
    .stall_err(stall_err), .timeout_err(timeout_err), .busy(busy)
  );

  dev_info_poller #(.INPUT_CLOCK(10_000), .POLL_MS(2), .TIMEOUT_CLK(1024)) u_auto (
    .clk(clk), .reset(reset),
    .avm_address(b_address), .avm_read(b_read), .avm_waitrequest(b_waitrequest),
    .avm_readdata(b_readdata), .avm_readdatavalid(b_readdatavalid),
    .start(b_start), .err_clr(1'b0), .snap_sel(3'd0), .snap_data(b_snap_data),
    .snap_valid(b_snap_valid), .snap_ready(b_snap_ready), .magic_err(b_magic_err),
    .stall_err(b_stall_err), .timeout_err(b_timeout_err), .busy(b_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // ---------------- slave for u_dut (acts at negedge) ----------------
  logic [31:0] mem [8];
  int          wait_addr = -1, wait_len = 0, drop_addr = -1;
  logic        inject = 1'b0;
  int          stall_cnt = 0, a4_cycles = 0, sv_count = 0;
  logic        acc_prev = 1'b0, wr_prev = 1'b0;
  logic [2:0]  acc_addr_prev = '0, addr_prev = '0;
  logic [2:0]  acc_q [$];

  always @(negedge clk) begin
    if (acc_prev && int'(acc_addr_prev) != drop_addr) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem[acc_addr_prev];
    end else if (inject) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'hDEAD_BEEF;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
    end
    if (wr_prev && !reset) begin
      check("hold_read", avm_read, 1'b1);
      check("hold_addr", avm_address, addr_prev);
    end
    if (avm_read && avm_address == 3'd4) a4_cycles++;
    if (snap_valid) sv_count++;
    if (avm_read && int'(avm_address) == wait_addr && stall_cnt < wait_len) begin
      avm_waitrequest = 1'b1;
      stall_cnt++;
    end else begin
      avm_waitrequest = 1'b0;
      stall_cnt = 0;
    end
    wr_prev       = avm_read && avm_waitrequest;
    addr_prev     = avm_address;
    acc_prev      = avm_read && !avm_waitrequest;
    acc_addr_prev = avm_address;
    if (acc_prev) acc_q.push_back(avm_address);
  end

  // ---------------- slave and busy monitor for u_auto ----------------
  int   b_slow = 0, b_stall = 0, cyc = 0;
  logic b_acc_prev = 1'b0, b_busy_prev = 1'b0;
  logic [2:0] b_acc_addr = '0;
  int   b_rise [$];
  int   b_fall [$];

  always @(negedge clk) begin
    cyc++;
    b_readdatavalid = b_acc_prev;
    b_readdata      = {29'd0, b_acc_addr} + 32'h100;
    if (b_read && b_address == 3'd0 && b_stall < b_slow) begin
      b_waitrequest = 1'b1;
      b_stall++;
    end else begin
      b_waitrequest = 1'b0;
      b_stall = 0;
    end
    b_acc_prev = b_read && !b_waitrequest;
    b_acc_addr = b_address;
    if (b_busy && !b_busy_prev) b_rise.push_back(cyc);
    if (!b_busy && b_busy_prev) b_fall.push_back(cyc);
    b_busy_prev = b_busy;
  end

  // ---------------- reference model ----------------
  logic [31:0] exp_shadow [8];
  logic        exp_ready, exp_magic, exp_stall, exp_timeout;

  task automatic model_commit();
    exp_magic  = exp_magic | (mem[0] != Magic);
    exp_stall  = exp_stall | (exp_ready && mem[2] == exp_shadow[2]);
    for (int i = 0; i < 8; i++) exp_shadow[i] = mem[i];
    exp_ready  = 1'b1;
  endtask

  task automatic model_clear_errs();
    exp_magic = 1'b0; exp_stall = 1'b0; exp_timeout = 1'b0;
  endtask

  task automatic new_words(input logic [31:0] w0, input logic [31:0] w2);
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    mem[0] = w0;
    mem[2] = w2;
  endtask

  // Pulse start, then wait for the snapshot pulse; returns at the negedge it is seen.
  task automatic run_poll(input string tag);
    bit seen = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (snap_valid) seen = 1;
    end
    check({tag, "_snap_valid"}, seen, 1'b1);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_magic_err"}, magic_err, exp_magic);
    check({tag, "_stall_err"}, stall_err, exp_stall);
    check({tag, "_timeout_err"}, timeout_err, exp_timeout);
    check({tag, "_snap_ready"}, snap_ready, exp_ready);
  endtask

  task automatic check_snapshot(input string tag);
    for (int i = 0; i < 8; i++) begin
      snap_sel = 3'(i);
      @(negedge clk);
      check($sformatf("%s_word%0d", tag, i), snap_data, exp_shadow[i]);
    end
  endtask

  task automatic check_addrs(input string tag, input int base);
    logic [23:0] got, exp;
    check({tag, "_read_count"}, acc_q.size() - base, 8);
    got = '0;
    exp = '0;
    for (int i = 0; i < 8 && base + i < acc_q.size(); i++) got[i*3 +: 3] = acc_q[base + i];
    for (int i = 0; i < 8; i++) exp[i*3 +: 3] = 3'(i);
    check({tag, "_addr_seq"}, got, exp);
  endtask

  initial begin
    int base, sv0, a0, n0, t_first, t_last;
    longint t0, t1;
    bit found, any_busy;

    reset = 1'b1; start = 1'b0; err_clr = 1'b0; snap_sel = '0; b_start = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    b_waitrequest = 1'b0; b_readdatavalid = 1'b0; b_readdata = '0;
    for (int i = 0; i < 8; i++) begin mem[i] = '0; exp_shadow[i] = '0; end
    exp_ready = 1'b0;
    model_clear_errs();

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_read", avm_read, 1'b0);
    check("rst_addr", avm_address, 3'd0);
    check("rst_snap_valid", snap_valid, 1'b0);
    check("rst_snap_data", snap_data, 32'd0);
    check_flags("rst");
    reset = 1'b0;

    // Autonomous polls every 20 cycles; start during a poll changes nothing.
    for (int i = 0; i < 400 && b_rise.size() < 2; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("auto_busy_at_start", b_busy, 1'b1);
    b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    for (int i = 0; i < 400 && b_rise.size() < 5; i++) @(negedge clk);
    check("auto_polls_seen", b_rise.size() >= 5, 1'b1);
    if (b_rise.size() >= 5) begin
      for (int i = 2; i < 5; i++) check($sformatf("auto_period%0d", i), b_rise[i] - b_rise[i-1], 20);
    end
    // Polls made longer than the period: the request waits and is serviced right after.
    b_slow = 10;
    n0 = b_rise.size();
    for (int i = 0; i < 600 && b_rise.size() < n0 + 3; i++) @(negedge clk);
    check("slow_polls_seen", b_rise.size() >= n0 + 3, 1'b1);
    if (b_rise.size() >= n0 + 3 && b_fall.size() > 0) begin
      t_last  = b_rise[b_rise.size()-1];
      t_first = b_rise[b_rise.size()-2];
      check("pending_idle_gap", t_last - b_fall[b_fall.size()-1], 1);
      check("slow_poll_len", b_fall[b_fall.size()-1] - t_first, 27);
    end
    b_slow = 0;

    // Basic poll with a zero-wait slave.
    new_words(Magic, 32'd1000);
    mem[1] = 32'd5;
    base = acc_q.size(); sv0 = sv_count;
    run_poll("basic");
    model_commit();
    check_flags("basic");
    check_addrs("basic", base);
    snap_sel = 3'd1;
    @(negedge clk);
    check("basic_sel1", snap_data, 32'd5);
    check("basic_pulse_count", sv_count - sv0, 1);

    // Waitrequest for three cycles on address 4.
    new_words(Magic, 32'd2000);
    wait_addr = 4; wait_len = 3;
    a0 = a4_cycles; base = acc_q.size();
    run_poll("wait4");
    model_commit();
    check("wait4_addr4_cycles", a4_cycles - a0, 4);
    check_addrs("wait4", base);
    check_snapshot("wait4");

    // Randomized polls.
    for (int k = 0; k < 6; k++) begin
      string tag;
      tag = $sformatf("rnd%0d", k);
      new_words(($urandom_range(0, 3) == 0) ? $urandom : Magic,
                ($urandom_range(0, 3) == 0) ? exp_shadow[2] : $urandom);
      wait_addr = $urandom_range(0, 7);
      wait_len  = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        model_clear_errs();
      end
      base = acc_q.size();
      run_poll(tag);
      model_commit();
      check_flags(tag);
      check_addrs(tag, base);
      check_snapshot(tag);
    end
    wait_addr = -1;

    // Bad magic, then two commits with the same runtime value.
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    model_clear_errs();
    new_words(32'h1234_5678, 32'd42);
    run_poll("magic");
    model_commit();
    check_flags("magic");
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    model_clear_errs();
    new_words(Magic, 32'd42);
    run_poll("stall");
    model_commit();
    check_flags("stall");

    // err_clr held through a commit that sets magic_err: the set wins.
    err_clr = 1'b1;
    model_clear_errs();
    new_words(32'hBAD0_0000, $urandom);
    run_poll("clr_race");
    model_commit();
    check("clr_race_magic_err", magic_err, 1'b1);
    err_clr = 1'b0;
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    model_clear_errs();
    check("clr_race_cleared", magic_err, 1'b0);

    // Start pulsed mid-poll does not queue another poll.
    new_words(Magic, $urandom);
    base = acc_q.size();
    run_poll("restart");
    model_commit();
    any_busy = 0;
    repeat (6) begin @(negedge clk); if (busy) any_busy = 1; end
    new_words(Magic, $urandom);
    base = acc_q.size();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin @(negedge clk); if (snap_valid) found = 1; end
    check("busy_start_snap_valid", found, 1'b1);
    model_commit();
    repeat (8) begin @(negedge clk); if (busy) any_busy = 1; end
    check("busy_start_ignored", any_busy, 1'b0);
    check_addrs("busy_start", base);

    // Address 6 never answers: timeout, prior snapshot kept.
    new_words(Magic, $urandom);
    drop_addr = 6;
    sv0 = sv_count;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 0; t0 = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (avm_read && avm_address == 3'd6) begin found = 1; t0 = $time; end
      else @(negedge clk);
    end
    check("to_reached_addr6", found, 1'b1);
    found = 0; t1 = t0;
    for (int i = 0; i < ToClk * 4 && !found; i++) begin
      @(negedge clk);
      if (!busy) begin found = 1; t1 = $time; end
    end
    check("to_busy_dropped", found, 1'b1);
    check("to_cycles", 32'((t1 - t0) / 10), ToClk);
    exp_timeout = 1'b1;
    check_flags("to");
    check("to_no_snap_valid", sv_count - sv0, 0);
    check_snapshot("to");
    drop_addr = -1;
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    model_clear_errs();
    check("to_cleared", timeout_err, 1'b0);

    // Reset while waiting on address 3; a late readdatavalid afterwards is ignored.
    new_words(32'h0BAD_0BAD, $urandom);
    run_poll("pre_rst");
    model_commit();
    new_words(Magic, $urandom);
    drop_addr = 3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (avm_read && avm_address == 3'd3) found = 1;
      else @(negedge clk);
    end
    check("rst_reached_addr3", found, 1'b1);
    @(negedge clk);
    check("rst_in_wait_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) exp_shadow[i] = '0;
    exp_ready = 1'b0;
    model_clear_errs();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_read", avm_read, 1'b0);
    check("mid_rst_addr", avm_address, 3'd0);
    check("mid_rst_snap_data", snap_data, 32'd0);
    check("mid_rst_snap_valid", snap_valid, 1'b0);
    check_flags("mid_rst");
    inject = 1'b1;
    repeat (2) @(negedge clk);
    inject = 1'b0;
    drop_addr = -1;
    any_busy = 0;
    repeat (4) begin @(negedge clk); if (busy || snap_valid) any_busy = 1; end
    check("late_rdv_ignored", any_busy, 1'b0);
    check_flags("late_rdv");
    check_snapshot("late_rdv");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dev_info_poller.md
DEV_INFO_POLLER -- requirements
Module: dev_info_poller

Interface
REQ-001 Parameters SHALL be: INPUT_CLOCK, default 100_000_000, clock frequency in Hz; POLL_MS, default 100, poll period in ms; TIMEOUT_CLK, default 1024, per-read timeout in clk cycles.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  single clock
  reset  in  1  reset, synchronous, active-high
  avm_address  out  3  Avalon-MM read address, selects device-info word 0..7
  avm_read  out  1  read request
  avm_waitrequest  in  1  slave stall; tie 0 for slaves without it
  avm_readdata  in  32  read data
  avm_readdatavalid  in  1  read data valid
  start  in  1  one-cycle manual poll trigger
  err_clr  in  1  clears sticky error flags
  snap_sel  in  3  snapshot word select
  snap_data  out  32  registered snapshot word for snap_sel
  snap_valid  out  1  one-cycle pulse on snapshot commit
  snap_ready  out  1  high once at least one snapshot has committed
  magic_err  out  1  sticky: word 0 != 32'h4D464441
  stall_err  out  1  sticky: word 2 (runtime) unchanged since previous commit
  timeout_err  out  1  sticky: read not completed within TIMEOUT_CLK
  busy  out  1  high while a poll is in progress

Function
REQ-003 A ms prescaler SHALL count 0..INPUT_CLOCK/1000-1 and wrap; a poll counter SHALL count ms ticks and request a poll at POLL_MS ticks, then restart from 0.
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, COMMIT.
REQ-005 IDLE -> REQ on a poll request or start; word index SHALL be set to 0; start SHALL be ignored while busy=1.
REQ-006 In REQ, avm_read SHALL be 1 and avm_address SHALL equal the word index; both SHALL be held stable while avm_waitrequest=1.
REQ-007 REQ -> WAIT on the cycle with avm_read=1 and avm_waitrequest=0; exactly one read SHALL be outstanding at a time.
REQ-008 In WAIT, avm_readdatavalid=1 SHALL store avm_readdata into staging[index]; if index=7 -> COMMIT, else index+1 and -> REQ.
REQ-009 Readdatavalid arriving in the cycle immediately after acceptance (one-cycle-latency slave) SHALL be captured; readdatavalid while in IDLE or REQ SHALL be ignored.
REQ-010 A timeout counter SHALL clear on entry to REQ; it SHALL increment in REQ and WAIT; on reaching TIMEOUT_CLK, timeout_err SHALL set, the FSM SHALL return to IDLE, the shadow registers SHALL remain unchanged and no snap_valid SHALL be issued.
REQ-011 COMMIT SHALL last one cycle and SHALL: copy all 8 staging words to shadow atomically; pulse snap_valid; set snap_ready; set magic_err if staging[0] != 32'h4D464441; set stall_err if snap_ready was already 1 and staging[2] == shadow[2]; then -> IDLE.
REQ-012 snap_data SHALL be shadow[snap_sel] registered, 1-cycle latency; it SHALL never show partially updated snapshots.
REQ-013 busy SHALL be 1 in REQ, WAIT and COMMIT.
REQ-014 Sticky errors SHALL be cleared by err_clr; a set condition in the same cycle as err_clr SHALL win.
REQ-015 A poll request raised while busy SHALL be held pending and serviced on return to IDLE; further requests SHALL not accumulate beyond one.

Reset
REQ-016 While reset=1 on a clk edge, the block SHALL enter IDLE and clear: prescaler, poll counter, index, timeout counter, pending request, staging, shadow, snap_data, all error flags, snap_valid, snap_ready, busy, avm_read, and avm_address.
REQ-017 Reset asserted mid-poll SHALL abandon the poll; readdatavalid following reset SHALL be ignored.

Verification
REQ-018 Model a zero-wait slave with 1-cycle readdatavalid returning {4D464441,5,R,A,V,C,T,H}; pulse start -> 8 reads at addresses 0..7, snap_valid after the 8th readdatavalid, snap_sel=1 -> snap_data=5, no errors.
REQ-019 Slave asserts waitrequest for 3 cycles on address 4 -> avm_address=4 and avm_read stable for 4 cycles, snapshot correct.
REQ-020 Slave never returns readdatavalid for address 6 -> timeout_err=1 after TIMEOUT_CLK cycles, shadow keeps the prior snapshot, busy=0; err_clr -> timeout_err=0.
REQ-021 Word 0 = 32'h12345678 -> magic_err=1 at COMMIT; two polls with runtime=42 both times -> stall_err=1 on the second commit only.
REQ-022 With INPUT_CLOCK=10_000 and POLL_MS=2 -> polls start every 20 cycles with no start pulse; start while busy is ignored.
REQ-023 Reset asserted while state=WAIT for address 3 -> IDLE next cycle, all outputs 0, late readdatavalid ignored.
